// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch controller: walks PC -> MAR -> program memory -> MDR -> IR,
// then hands the instruction to decode over a valid/ready handshake.
module fetch_sequencer #(
  parameter int                ADDR_W   = 5,
  parameter int                CNT_W    = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              halt,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic              out_ready,
  input  logic              pm_load_req,
  output logic              pm_load_gnt,
  output logic [ADDR_W-1:0] pc_addr,
  output logic              mar_wr,
  output logic              pm_rd,
  output logic              mdr_wr,
  output logic              ir_wr,
  output logic              out_valid,
  output logic              busy,
  output logic [CNT_W-1:0]  fetch_count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    READ  = 3'd2,
    LATCH = 3'd3,
    LOAD  = 3'd4,
    VALID = 3'd5
  } state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] pc, pc_next;
  logic [CNT_W-1:0]  count, count_next;
  logic              halt_pending, halt_pending_next;
  logic              handshake;
  logic              stop_after;

  assign handshake  = (state == VALID) && out_ready;
  assign stop_after = halt_pending || halt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      count        <= '0;
      halt_pending <= 1'b0;
    end else begin
      state        <= state_next;
      pc           <= pc_next;
      count        <= count_next;
      halt_pending <= halt_pending_next;
    end
  end

  // A handshake retires the instruction even when a redirect lands on the same cycle.
  always_comb begin
    state_next        = state;
    pc_next           = pc;
    count_next        = count;
    halt_pending_next = halt_pending;
    if (state == IDLE) begin
      if (redirect_valid) begin
        pc_next = redirect_addr;
      end else if (start && !halt && !pm_load_req) begin
        state_next = ADDR;
      end
    end else begin
      halt_pending_next = stop_after;
      if (handshake) begin
        count_next = count + 1'b1;
        pc_next    = redirect_valid ? redirect_addr : pc + 1'b1;
        if (stop_after) begin
          state_next        = IDLE;
          halt_pending_next = 1'b0;
        end else begin
          state_next = ADDR;
        end
      end else if (redirect_valid) begin
        pc_next    = redirect_addr;
        state_next = ADDR;
      end else begin
        case (state)
          ADDR:    state_next = READ;
          READ:    state_next = LATCH;
          LATCH:   state_next = LOAD;
          LOAD:    state_next = VALID;
          default: state_next = state;
        endcase
      end
    end
  end

  assign mar_wr      = (state == ADDR);
  assign pm_rd       = (state == READ);
  assign mdr_wr      = (state == LATCH);
  assign ir_wr       = (state == LOAD);
  assign out_valid   = (state == VALID);
  assign busy        = (state != IDLE);
  assign pm_load_gnt = (state == IDLE) && pm_load_req;
  assign pc_addr     = pc;
  assign fetch_count = count;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed scenarios followed by random
// traffic, checked against a stage-counter reference model.
module tb_fetch_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, halt = 1'b0, rv = 1'b0, ordy = 1'b0, plr = 1'b0;
  logic [4:0] ra = '0;

  logic        gnt, mar_wr, pm_rd, mdr_wr, ir_wr, out_valid, busy;
  logic [4:0]  pc_addr;
  logic [15:0] fetch_count;

  logic        start2 = 1'b1;
  logic        gnt2, mar_wr2, pm_rd2, mdr_wr2, ir_wr2, out_valid2, busy2;
  logic [4:0]  pc_addr2;
  logic [3:0]  fetch_count2;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(.ADDR_W(5), .CNT_W(16), .RESET_PC(5'd0)) dut (
    .clk(clk), .reset(rst), .start(start), .halt(halt),
    .redirect_valid(rv), .redirect_addr(ra), .out_ready(ordy),
    .pm_load_req(plr), .pm_load_gnt(gnt), .pc_addr(pc_addr),
    .mar_wr(mar_wr), .pm_rd(pm_rd), .mdr_wr(mdr_wr), .ir_wr(ir_wr),
    .out_valid(out_valid), .busy(busy), .fetch_count(fetch_count)
  );

  // Narrow counter and a PC near the top of memory so both wraps happen quickly.
  fetch_sequencer #(.ADDR_W(5), .CNT_W(4), .RESET_PC(5'd30)) dut_wrap (
    .clk(clk), .reset(rst), .start(start2), .halt(1'b0),
    .redirect_valid(1'b0), .redirect_addr(5'd0), .out_ready(1'b1),
    .pm_load_req(1'b0), .pm_load_gnt(gnt2), .pc_addr(pc_addr2),
    .mar_wr(mar_wr2), .pm_rd(pm_rd2), .mdr_wr(mdr_wr2), .ir_wr(ir_wr2),
    .out_valid(out_valid2), .busy(busy2), .fetch_count(fetch_count2)
  );

  typedef struct { int pc; int cnt; } exp_t;
  exp_t sb[$];

  // Reference model: m_phase counts cycles since the fetch began (1..5).
  bit m_active = 0;
  int m_phase  = 0;
  int m_pc     = 0;
  int m_cnt    = 0;
  bit m_hp     = 0;
  int n2       = 0;
  int max_n2   = 0;

  always @(posedge clk) begin
    bit hs, stop;
    if (rst) begin
      m_active = 0; m_phase = 0; m_pc = 0; m_cnt = 0; m_hp = 0; n2 = 0;
    end else if (!m_active) begin
      if (rv) m_pc = int'(ra);
      else if (start && !halt && !plr) begin m_active = 1; m_phase = 1; end
    end else begin
      hs   = (m_phase == 5) && ordy;
      stop = m_hp || halt;
      m_hp = stop;
      if (hs) begin
        m_cnt = (m_cnt + 1) % 65536;
        m_pc  = rv ? int'(ra) : (m_pc + 1) % 32;
        if (stop) begin m_active = 0; m_phase = 0; m_hp = 0; end
        else m_phase = 1;
      end else if (rv) begin
        m_pc = int'(ra); m_phase = 1;
      end else if (m_phase < 5) begin
        m_phase = m_phase + 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    else
      pass_cnt++;
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [6:0] exp_vec;
    exp_vec = {m_active && m_phase == 1, m_active && m_phase == 2, m_active && m_phase == 3,
               m_active && m_phase == 4, m_active && m_phase == 5, m_active, !m_active && plr};
    checkOutput("strobes", {25'd0, mar_wr, pm_rd, mdr_wr, ir_wr, out_valid, busy, gnt}, {25'd0, exp_vec});
    checkOutput("pc_addr", {27'd0, pc_addr}, m_pc);
    checkOutput("fetch_count", {16'd0, fetch_count}, m_cnt);
    if (out_valid && ordy) begin
      if (sb.size() == 0) begin
        checkOutput("handshake_expected", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("handshake_pc", {27'd0, pc_addr}, e.pc);
        checkOutput("handshake_count", {16'd0, fetch_count}, e.cnt);
      end
    end
    if (!rst && out_valid2) begin
      checkOutput("wrap_count", {28'd0, fetch_count2}, n2 % 16);
      checkOutput("wrap_pc", {27'd0, pc_addr2}, (30 + n2) % 32);
      n2++;
      if (n2 > max_n2) max_n2 = n2;
    end
  end

  // Inputs are set now and held across the next rising edge.
  task automatic applyStimulus(input bit r, input bit s, input bit h, input bit rvv,
                               input logic [4:0] raa, input bit o, input bit p);
    exp_t e;
    rst = r; start = s; halt = h; rv = rvv; ra = raa; ordy = o; plr = p;
    if (m_active && m_phase == 5 && o) begin
      e.pc = m_pc; e.cnt = m_cnt;
      sb.push_back(e);
    end
    @(posedge clk);
    #2;
  endtask

  task automatic waitPhase(input int k);
    for (int i = 0; i < 20 && !(m_active && m_phase == k); i++)
      applyStimulus(0, 0, 0, 0, 5'd0, 1, 0);
    checkOutput("reached_phase", {31'd0, m_active && m_phase == k}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    repeat (2) applyStimulus(1, 0, 0, 0, 5'd0, 1, 0);
    applyStimulus(0, 1, 0, 0, 5'd0, 1, 0);
    repeat (9) applyStimulus(0, 0, 0, 0, 5'd0, 1, 0);
    repeat (15) applyStimulus(0, 0, 0, 0, 5'd0, 0, 0);
    repeat (200) applyStimulus(0, 0, 0, 0, 5'd0, 1, 0);

    waitPhase(2);
    applyStimulus(0, 0, 0, 1, 5'd12, 1, 0);
    waitPhase(5);
    applyStimulus(0, 0, 0, 1, 5'd12, 1, 0);

    waitPhase(3);
    applyStimulus(0, 0, 1, 0, 5'd0, 1, 0);
    repeat (10) applyStimulus(0, 0, 0, 0, 5'd0, 1, 0);
    repeat (3) applyStimulus(0, 1, 1, 0, 5'd0, 1, 0);

    applyStimulus(0, 1, 0, 0, 5'd0, 1, 0);
    waitPhase(4);
    applyStimulus(0, 0, 1, 0, 5'd0, 1, 1);
    repeat (12) applyStimulus(0, 1, 0, 0, 5'd0, 1, 1);

    applyStimulus(0, 1, 0, 0, 5'd0, 1, 0);
    waitPhase(2);
    applyStimulus(1, 0, 0, 0, 5'd0, 1, 0);
    applyStimulus(0, 0, 0, 0, 5'd0, 1, 0);

    for (int i = 0; i < 3000; i++)
      applyStimulus($urandom_range(999) < 2, $urandom_range(99) < 30, $urandom_range(99) < 5,
                    $urandom_range(99) < 5, 5'($urandom_range(31)), $urandom_range(99) < 60,
                    $urandom_range(99) < 10);

    repeat (10) applyStimulus(0, 0, 0, 0, 5'd0, 1, 0);
    checkOutput("sb_drain", sb.size(), 32'd0);
    checkOutput("wrap_seen", {31'd0, max_n2 > 16}, 32'd1);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
